// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 op codes,
// FSM state encoding and operand-signedness helpers.
package muldiv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    // Dividend that overflows a signed divide by -1.
    localparam logic [XLEN_DEFAULT-1:0] DIV_OVF_A = {1'b1, {(XLEN_DEFAULT-1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix,
        StDone
    } state_e;

    function automatic logic op_a_signed(input logic [2:0] op);
        logic s;
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: s = 1'b1;
            default:                                    s = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic op_b_signed(input logic [2:0] op);
        logic s;
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: s = 1'b1;
            default:                         s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer datapath: shift-add multiply step or
// restoring divide step on a {high, low} double-width accumulator.
module muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic              mode_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_out,
    output logic              q_bit
);

    logic [XLEN:0]   mul_sum;
    logic [2*XLEN:0] sh;
    logic [XLEN+1:0] diff;
    logic            borrow;

    always_comb begin
        // Multiply: low half holds the remaining multiplier bits, LSB first.
        mul_sum = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);

        // Divide: shift {rem, dividend} left, trial-subtract divisor from rem.
        sh     = {acc_in, 1'b0};
        diff   = {1'b0, sh[2*XLEN:XLEN]} - {2'b00, operand};
        borrow = diff[XLEN+1];
        q_bit  = ~borrow;

        if (mode_div) begin
            acc_out = {(borrow ? sh[2*XLEN-1:XLEN] : diff[XLEN-1:0]), sh[XLEN-1:1], 1'b0};
        end else begin
            acc_out = {mul_sum, acc_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU; stalls the
// pipeline while running and returns result plus destination register.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [4:0]      rd_in,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int unsigned     CntW    = $clog2(XLEN);
    localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);
    localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;

    logic              accept;
    logic              sign_a, sign_b;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   special_res;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   div_sel;
    logic [XLEN-1:0]   fix_res;
    logic [2*XLEN-1:0] step_acc;
    logic              step_q;

    muldiv_step #(
        .XLEN(XLEN)
    ) u_step (
        .mode_div(op_q[2]),
        .acc_in  (acc_q),
        .operand (opnd_q),
        .acc_out (step_acc),
        .q_bit   (step_q)
    );

    always_comb begin
        accept   = (state_q == StIdle) && start && !flush;
        sign_a   = op_a_signed(op) & src_a[XLEN-1];
        sign_b   = op_b_signed(op) & src_b[XLEN-1];
        abs_a    = sign_a ? -src_a : src_a;
        abs_b    = sign_b ? -src_b : src_b;
        div_zero = op[2] && (src_b == '0);
        div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (src_a == MinNeg) && (src_b == '1);

        // op[1] selects remainder (REM/REMU) over quotient among the divides.
        if (div_zero) begin
            special_res = op[1] ? src_a : '1;
        end else begin
            special_res = op[1] ? '0 : MinNeg;
        end

        prod    = neg_q ? -acc_q : acc_q;
        div_sel = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        if (!op_q[2]) begin
            fix_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else begin
            fix_res = neg_q ? -div_sel : div_sel;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rd_d      = rd_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        neg_d     = neg_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;
        stall_req = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    stall_req = 1'b1;
                    op_d      = op;
                    rd_d      = rd_in;
                    cnt_d     = CntLast;
                    if (div_zero || div_ovf) begin
                        state_d  = StDone;
                        result_d = special_res;
                        rd_out_d = rd_in;
                    end else if (op[2]) begin
                        state_d = StRun;
                        acc_d   = {{XLEN{1'b0}}, abs_a};
                        opnd_d  = abs_b;
                        neg_d   = op[1] ? sign_a : (sign_a ^ sign_b);
                    end else begin
                        state_d = StRun;
                        acc_d   = {{XLEN{1'b0}}, abs_b};
                        opnd_d  = abs_a;
                        neg_d   = sign_a ^ sign_b;
                    end
                end
            end
            StRun: begin
                if (flush) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    stall_req = 1'b1;
                    acc_d     = {step_acc[2*XLEN-1:1], (op_q[2] ? step_q : step_acc[0])};
                    if (cnt_q == '0) begin
                        state_d = StFix;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            StFix: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    stall_req = 1'b1;
                    result_d  = fix_res;
                    rd_out_d  = rd_q;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer with hand-computed results.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  rd_in;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_total = 0;
    int n_bad   = 0;

    muldiv_sequencer #(
        .XLEN(32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .flush    (flush),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .rd_in    (rd_in),
        .stall_req(stall_req),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .rd_out   (rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Issue one op and wait for done; latency counts edges after the accepting edge.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int lat, output logic [31:0] res,
                          output logic [4:0] rdo, output logic stall_ok);
        @(negedge clk);
        op = o; src_a = a; src_b = b; rd_in = rd; start = 1'b1;
        #1;
        stall_ok = stall_req;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 100) begin
            stall_ok &= stall_req;
            @(posedge clk);
            #1;
            lat++;
        end
        stall_ok &= !stall_req;
        res = result;
        rdo = rd_out;
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    typedef struct {
        string       tag;
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int          lat;
        logic [31:0] res;
        logic [4:0]  rdo;
        logic        sok;
        int          pulses;

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0; rd_in = '0;
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd", {27'd0, rd_out}, 32'd0);
        #20;
        rst = 1'b0;

        vecs.push_back('{"mul_7x-3",       3'b000, 32'd7,         32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 34});
        vecs.push_back('{"mulhu_ff",       3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 34});
        vecs.push_back('{"mulh_ff",        3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000, 34});
        vecs.push_back('{"mulhsu_ff",      3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 34});
        vecs.push_back('{"div_-20_3",      3'b100, 32'hFFFF_FFEC, 32'd3,         5'd5, 32'hFFFF_FFFA, 34});
        vecs.push_back('{"rem_-20_3",      3'b110, 32'hFFFF_FFEC, 32'd3,         5'd6, 32'hFFFF_FFFE, 34});
        vecs.push_back('{"divu_100_7",     3'b101, 32'd100,       32'd7,         5'd7, 32'd14,        34});
        vecs.push_back('{"remu_100_7",     3'b111, 32'd100,       32'd7,         5'd0, 32'd2,         34});
        vecs.push_back('{"divu_5_0",       3'b101, 32'd5,         32'd0,         5'd8, 32'hFFFF_FFFF, 1});
        vecs.push_back('{"rem_5_0",        3'b110, 32'd5,         32'd0,         5'd9, 32'd5,         1});
        vecs.push_back('{"div_ovf",        3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1});
        vecs.push_back('{"rem_ovf",        3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0,        1});

        foreach (vecs[i]) begin
            run_op(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].rd, lat, res, rdo, sok);
            check({vecs[i].tag, "_res"}, res, vecs[i].exp);
            check({vecs[i].tag, "_lat"}, lat, vecs[i].lat);
            check({vecs[i].tag, "_rd"}, {27'd0, rdo}, {27'd0, vecs[i].rd});
            check({vecs[i].tag, "_stall"}, {31'd0, sok}, 32'd1);
        end

        // Flush a DIV in cycle T+10.
        @(negedge clk);
        op = 3'b100; src_a = 32'd1000; src_b = 32'd3; rd_in = 5'd12; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check("flush_stall_drop", {31'd0, stall_req}, 32'd0);
        check("flush_busy_before", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy_after", {31'd0, busy}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            @(posedge clk);
            #1;
        end
        check("flush_no_done", pulses, 0);

        // Flush together with start in IDLE: not accepted.
        @(negedge clk);
        op = 3'b000; src_a = 32'd5; src_b = 32'd5; start = 1'b1; flush = 1'b1;
        #1;
        check("flush_idle_stall", {31'd0, stall_req}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("flush_idle_busy", {31'd0, busy}, 32'd0);

        run_op(3'b000, 32'd2, 32'd3, 5'd13, lat, res, rdo, sok);
        check("mul_2x3_res", res, 32'd6);
        check("mul_2x3_lat", lat, 34);

        // Asynchronous reset mid-RUN.
        @(negedge clk);
        op = 3'b000; src_a = 32'd9; src_b = 32'd9; rd_in = 5'd14; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_stall", {31'd0, stall_req}, 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_rd", {27'd0, rd_out}, 32'd0);
        #2;
        rst = 1'b0;

        // start held high while busy, operands changed after acceptance.
        @(negedge clk);
        op = 3'b101; src_a = 32'd100; src_b = 32'd7; rd_in = 5'd15; start = 1'b1;
        @(posedge clk);
        #1;
        src_a  = 32'd50;
        src_b  = 32'd3;
        pulses = 0;
        res    = '0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                pulses++;
                res   = result;
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("held_pulses", pulses, 1);
        check("held_res", res, 32'd14);
        check("held_rd", {27'd0, rd_out}, 32'd15);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
